// File: rtl/shifter_defs_pkg.sv
// shifter_defs: direction/mode bit meanings shared by the sequential shifter and ALU decode.
package shifter_defs;

  localparam logic DIR_LEFT   = 1'b0;
  localparam logic DIR_RIGHT  = 1'b1;
  localparam logic FILL_ZERO  = 1'b0;
  localparam logic FILL_ARITH = 1'b1;
  localparam logic ROT_OFF    = 1'b0;
  localparam logic ROT_ON     = 1'b1;

  typedef struct packed {
    logic lr;
    logic la;
    logic rot;
  } shift_mode_t;

endpackage

// File: rtl/shift_step.sv
// shift_step: one-bit left/right shift or rotate with selectable right-shift fill.
module shift_step
  import shifter_defs::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] y,
  input  logic             lr,
  input  logic             la,
  input  logic             rot,
  output logic [WIDTH-1:0] y_next,
  output logic             c_next
);
  logic l_fill;
  logic r_fill;
  always_comb begin
    l_fill = rot == ROT_ON ? y[WIDTH-1] : 1'b0;
    r_fill = rot == ROT_ON ? y[0] : (la == FILL_ARITH ? y[WIDTH-1] : 1'b0);
    y_next = lr == DIR_RIGHT ? {r_fill, y[WIDTH-1:1]} : {y[WIDTH-2:0], l_fill};
    c_next = lr == DIR_RIGHT ? y[0] : y[WIDTH-1];
  end
endmodule

// File: rtl/seq_shifter.sv
// seq_shifter: multi-cycle shifter stepping one bit per clock through IDLE/SHIFT/DONE.
module seq_shifter
  import shifter_defs::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [AMT_W-1:0] amt,
  input  logic             lr,
  input  logic             la,
  input  logic             rot,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic             c
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;
  logic [1:0]       state;
  logic [AMT_W-1:0] cnt;
  shift_mode_t      mode;
  logic [WIDTH-1:0] y_nx;
  logic             c_nx;
  logic             accept;
  assign accept = start && state != SHIFT;
  assign busy   = state == SHIFT;
  assign done   = state == DONE;
  shift_step #(.WIDTH(WIDTH)) u_step (
    .y      (y),
    .lr     (mode.lr),
    .la     (mode.la),
    .rot    (mode.rot),
    .y_next (y_nx),
    .c_next (c_nx)
  );
  // Inputs are only looked at on accept edges; the latched mode drives every step.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      y     <= '0;
      c     <= 1'b0;
      cnt   <= '0;
      mode  <= '0;
    end else if (accept) begin
      y     <= a;
      c     <= 1'b0;
      cnt   <= amt;
      mode  <= '{lr: lr, la: la, rot: rot};
      state <= amt != '0 ? SHIFT : DONE;
    end else if (state == SHIFT) begin
      y     <= y_nx;
      c     <= c_nx;
      cnt   <= cnt - 1'b1;
      state <= cnt == AMT_W'(1) ? DONE : SHIFT;
    end else if (state != IDLE) begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_seq_shifter.sv
// tb_seq_shifter: scoreboard-driven checks of seq_shifter results, latency, reset and back-to-back starts.
module tb_seq_shifter;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] a = '0;
  logic [3:0] amt = '0;
  logic       lr = 1'b0;
  logic       la = 1'b0;
  logic       rot = 1'b0;
  logic       busy;
  logic       done;
  logic [7:0] y;
  logic       c;

  typedef struct {
    logic [7:0] y;
    logic       c;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  seq_shifter #(.WIDTH(8), .AMT_W(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .amt   (amt),
    .lr    (lr),
    .la    (la),
    .rot   (rot),
    .busy  (busy),
    .done  (done),
    .y     (y),
    .c     (c)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void model(input logic [7:0] ai, input int n, input logic l, input logic ar,
                                input logic r, output logic [7:0] yo, output logic co);
    yo = ai;
    co = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (l) begin
        co = yo[0];
        yo = {r ? yo[0] : (ar ? yo[7] : 1'b0), yo[7:1]};
      end else begin
        co = yo[7];
        yo = {yo[6:0], r ? yo[7] : 1'b0};
      end
    end
  endfunction

  // Called at a negedge; returns at the negedge right after the accept edge.
  task automatic issue(input logic [7:0] ai, input logic [3:0] am, input logic l, input logic ar,
                       input logic r, input logic [7:0] ey, input logic ec);
    exp_t e;
    start = 1'b1;
    a = ai;
    amt = am;
    lr = l;
    la = ar;
    rot = r;
    e.y = ey;
    e.c = ec;
    e.lat = int'(am);
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    a = $urandom_range(255);
    amt = $urandom_range(15);
    lr = $urandom_range(1);
    la = $urandom_range(1);
    rot = $urandom_range(1);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({busy, done, c, y} !== 11'd0) begin
      n_err++;
      $display("FAIL reset_state: got busy=%b done=%b c=%b y=%h, want all zero", busy, done, c, y);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({busy, done} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_idle: got busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_left;
    int   n;
    exp_t e;
    issue(8'hB1, 4'd3, 1'b0, 1'b0, 1'b0, 8'h88, 1'b1);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL left_busy: got %b, want 1", busy);
    end
    wait_done(n);
    e = sb.pop_front();
    n_cmp++;
    if (n !== e.lat) begin
      n_err++;
      $display("FAIL left_latency: got %0d, want %0d", n, e.lat);
    end
    n_cmp++;
    if ({y, c} !== {e.y, e.c}) begin
      n_err++;
      $display("FAIL left_result: got y=%h c=%b, want y=%h c=%b", y, c, e.y, e.c);
    end
    @(negedge clk);
    n_cmp++;
    if ({done, busy, y, c} !== {2'b00, e.y, e.c}) begin
      n_err++;
      $display("FAIL left_hold: got done=%b busy=%b y=%h c=%b, want 0 0 %h %b", done, busy, y, c, e.y, e.c);
    end
  endtask

  task automatic test_right;
    int   n;
    exp_t e;
    issue(8'h90, 4'd2, 1'b1, 1'b1, 1'b0, 8'hE4, 1'b0);
    wait_done(n);
    e = sb.pop_front();
    n_cmp++;
    if ({y, c} !== {e.y, e.c} || n !== e.lat) begin
      n_err++;
      $display("FAIL right_arith: got y=%h c=%b lat=%0d, want y=%h c=%b lat=%0d", y, c, n, e.y, e.c, e.lat);
    end
    @(negedge clk);
    issue(8'h90, 4'd2, 1'b1, 1'b0, 1'b0, 8'h24, 1'b0);
    wait_done(n);
    e = sb.pop_front();
    n_cmp++;
    if ({y, c} !== {e.y, e.c} || n !== e.lat) begin
      n_err++;
      $display("FAIL right_logical: got y=%h c=%b lat=%0d, want y=%h c=%b lat=%0d", y, c, n, e.y, e.c, e.lat);
    end
    @(negedge clk);
  endtask

  task automatic test_rotate;
    int   n;
    exp_t e;
    issue(8'h81, 4'd1, 1'b1, 1'b0, 1'b1, 8'hC0, 1'b1);
    wait_done(n);
    e = sb.pop_front();
    n_cmp++;
    if ({y, c} !== {e.y, e.c} || n !== e.lat) begin
      n_err++;
      $display("FAIL rotr1: got y=%h c=%b lat=%0d, want y=%h c=%b lat=%0d", y, c, n, e.y, e.c, e.lat);
    end
    @(negedge clk);
    issue(8'h81, 4'd8, 1'b0, 1'b1, 1'b1, 8'h81, 1'b1);
    wait_done(n);
    e = sb.pop_front();
    n_cmp++;
    if ({y, c} !== {e.y, e.c} || n !== e.lat) begin
      n_err++;
      $display("FAIL rotl8: got y=%h c=%b lat=%0d, want y=%h c=%b lat=%0d", y, c, n, e.y, e.c, e.lat);
    end
    @(negedge clk);
    issue(8'hA5, 4'd12, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    wait_done(n);
    e = sb.pop_front();
    n_cmp++;
    if ({y, c} !== {e.y, e.c} || n !== e.lat) begin
      n_err++;
      $display("FAIL left_over_width: got y=%h c=%b lat=%0d, want y=%h c=%b lat=%0d", y, c, n, e.y, e.c, e.lat);
    end
    @(negedge clk);
  endtask

  task automatic test_zero_and_ignore;
    int   n;
    exp_t e;
    issue(8'h5A, 4'd0, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b0);
    n_cmp++;
    if ({done, busy, y, c} !== {2'b10, 8'h5A, 1'b0}) begin
      n_err++;
      $display("FAIL amt_zero: got done=%b busy=%b y=%h c=%b, want 1 0 5a 0", done, busy, y, c);
    end
    void'(sb.pop_front());
    @(negedge clk);
    issue(8'h3C, 4'd5, 1'b0, 1'b0, 1'b0, 8'h80, 1'b1);
    @(negedge clk);
    start = 1'b1;
    a = 8'hFF;
    amt = 4'd1;
    lr = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
    e = sb.pop_front();
    n_cmp++;
    if ({y, c} !== {e.y, e.c} || n + 2 !== e.lat) begin
      n_err++;
      $display("FAIL start_in_shift: got y=%h c=%b lat=%0d, want y=%h c=%b lat=%0d", y, c, n + 2, e.y, e.c, e.lat);
    end
    @(negedge clk);
  endtask

  task automatic test_abort;
    int seen = 0;
    issue(8'hFF, 4'd6, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    void'(sb.pop_back());
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if ({busy, done, y, c} !== 11'd0) begin
      n_err++;
      $display("FAIL abort_state: got busy=%b done=%b y=%h c=%b, want all zero", busy, done, y, c);
    end
    for (int i = 0; i < 12; i++) begin
      if (done === 1'b1) seen++;
      @(negedge clk);
    end
    n_cmp++;
    if (seen !== 0) begin
      n_err++;
      $display("FAIL abort_no_done: got %0d done cycles, want 0", seen);
    end
  endtask

  task automatic test_back_to_back;
    int   n1;
    int   n2;
    exp_t e;
    issue(8'hB1, 4'd3, 1'b0, 1'b0, 1'b0, 8'h88, 1'b1);
    wait_done(n1);
    e = sb.pop_front();
    n_cmp++;
    if ({y, c} !== {e.y, e.c} || n1 !== e.lat) begin
      n_err++;
      $display("FAIL b2b_first: got y=%h c=%b lat=%0d, want y=%h c=%b lat=%0d", y, c, n1, e.y, e.c, e.lat);
    end
    issue(8'h90, 4'd2, 1'b1, 1'b1, 1'b0, 8'hE4, 1'b0);
    n_cmp++;
    if ({busy, done} !== 2'b10) begin
      n_err++;
      $display("FAIL b2b_accept: got busy=%b done=%b, want 1 0", busy, done);
    end
    wait_done(n2);
    e = sb.pop_front();
    n_cmp++;
    if ({y, c} !== {e.y, e.c} || n2 !== e.lat) begin
      n_err++;
      $display("FAIL b2b_second: got y=%h c=%b lat=%0d, want y=%h c=%b lat=%0d", y, c, n2, e.y, e.c, e.lat);
    end
    @(negedge clk);
  endtask

  task automatic test_random;
    int         n;
    exp_t       e;
    logic [7:0] ra;
    logic [3:0] ram;
    logic       rl;
    logic       rla;
    logic       rr;
    logic [7:0] ey;
    logic       ec;
    for (int k = 0; k < 8; k++) begin
      ra = $urandom_range(255);
      ram = $urandom_range(15);
      rl = $urandom_range(1);
      rla = $urandom_range(1);
      rr = $urandom_range(1);
      model(ra, int'(ram), rl, rla, rr, ey, ec);
      issue(ra, ram, rl, rla, rr, ey, ec);
      wait_done(n);
      e = sb.pop_front();
      n_cmp++;
      if ({y, c} !== {e.y, e.c} || n !== e.lat) begin
        n_err++;
        $display("FAIL random_%0d: a=%h amt=%0d lr=%b la=%b rot=%b got y=%h c=%b lat=%0d, want y=%h c=%b lat=%0d",
                 k, ra, ram, rl, rla, rr, y, c, n, e.y, e.c, e.lat);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_left();
    test_right();
    test_rotate();
    test_zero_and_ignore();
    test_abort();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/seq_shifter.md
SEQ_SHIFTER -- requirements
Module: seq_shifter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width in bits, at least 2.
REQ-002 SHALL have parameter AMT_W, default 4, shift-amount width; any amt value 0..2^AMT_W-1 is legal.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-005 SHALL have port start  input  1  request; sampled with a, amt, lr, la, rot on the same edge.
REQ-006 SHALL have port a  input  WIDTH  operand.
REQ-007 SHALL have port amt  input  AMT_W  number of single-bit shift steps.
REQ-008 SHALL have port lr  input  1  direction: 0 = left, 1 = right.
REQ-009 SHALL have port la  input  1  right-shift fill: 1 = arithmetic (msb replicate), 0 = logical (zero); ignored on left shifts.
REQ-010 SHALL have port rot  input  1  1 = rotate, which overrides la.
REQ-011 SHALL have port busy  output  1  high while in SHIFT.
REQ-012 SHALL have port done  output  1  one-cycle completion pulse.
REQ-013 SHALL have port y  output  WIDTH  result register.
REQ-014 SHALL have port c  output  1  last bit shifted out.

Function
REQ-015 FSM SHALL have states IDLE, SHIFT and DONE; busy = (state==SHIFT) and done = (state==DONE), both decoded from registered state.
REQ-016 start SHALL be accepted only in IDLE or DONE and SHALL be ignored in SHIFT.
REQ-017 Accept SHALL load y<=a, c<=0, cnt<=amt and latch lr/la/rot; next state is SHIFT if amt!=0, else DONE.
REQ-018 Each SHIFT cycle SHALL perform one step and decrement cnt; when cnt reaches 0 the next state is DONE.
REQ-019 Left step SHALL do c<=y[WIDTH-1] and y<={y[WIDTH-2:0], fill}, with fill = rot ? y[WIDTH-1] : 0.
REQ-020 Right step SHALL do c<=y[0] and y<={fill, y[WIDTH-1:1]}, with fill = rot ? y[0] : (la ? y[WIDTH-1] : 0).
REQ-021 Latency SHALL be as follows: with start accepted at edge k, done SHALL be high for exactly the cycle following edge k+max(amt,1).
REQ-022 amt greater than or equal to WIDTH SHALL follow step-by-step semantics, with no saturation special case; logical results are 0 and c equals the fill bit of the final step.
REQ-023 If no start is present, DONE SHALL go to IDLE; a start in DONE SHALL be accepted with no idle bubble.
REQ-024 y and c SHALL hold their values from done until the next accepted start.
REQ-025 Inputs SHALL be ignored outside accept edges, so mid-operation changes to a, amt or mode have no effect.

Reset
REQ-026 While rst is high at a clock edge, the block SHALL set state=IDLE, y=0, c=0 and cnt=0; busy=0 and done=0 follow.
REQ-027 rst SHALL take priority over start on the same edge.
REQ-028 rst during SHIFT SHALL abort the operation with no done pulse.

Structure
REQ-029 State encodings SHALL be localparams inside seq_shifter; direction/mode bit meanings SHALL live in the shared shifter_defs header for reuse by ALU decode.
REQ-030 The single-step datapath of REQ-019/020 SHALL be a combinational sub-module shift_step (inputs y, lr, la, rot; outputs next y, c), instantiated once.

Verification (WIDTH=8, AMT_W=4)
REQ-031 a=8'hB1, amt=3, lr=0, rot=0 -> busy for 3 cycles, then done pulse with y=8'h88, c=1.
REQ-032 a=8'h90, amt=2, lr=1 -> la=1 gives y=8'hE4, c=0; la=0 gives y=8'h24, c=0.
REQ-033 Rotate cases -> rot=1, lr=1, a=8'h81, amt=1 gives y=8'hC0, c=1; rot=1, lr=0, amt=8 gives y=8'h81, c=1, with done 8 cycles after accept.
REQ-034 amt=0, a=8'h5A -> done the cycle after accept, y=8'h5A, c=0; a start pulsed during a SHIFT of amt=5 is ignored and y is unchanged by it.
REQ-035 rst asserted 2 cycles into an amt=6 shift -> next cycle y=0, c=0, busy=0, and no done pulse ever appears.
REQ-036 New start presented in the DONE cycle -> accepted; the second result is correct, and done pulses are separated by exactly amt2 cycles.
